main_mem_responder: RTL



---
 rtl/main_mem_responder_pkg.sv | 35 +++
 rtl/main_mem_responder_ram.sv | 37 +++
 rtl/main_mem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/main_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// main_mem_responder_pkg
//   Shared definitions for the main-memory responder: bus word width,
//   responder state encoding, operation type and the sequential-read
//   (in-row refill) detection helper.
// -----------------------------------------------------------------------------
package main_mem_responder_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   // cur/last are word addresses (byte address bits [31:2]).
   // A read is "sequential" when it targets the word right after the last
   // served one and stays inside the same row. The +1 wraps modulo 2^30, so
   // the 0xFFFF_FFFC -> 0x0 step always fails the row comparison.
   function automatic logic is_seq_word(input logic [29:0] cur,
                                        input logic [29:0] last,
                                        input int          row_bits);
      logic [29:0] next_word;
      next_word = last + 30'd1;
      return (cur == next_word) &&
             ((cur >> (row_bits - 2)) == (last >> (row_bits - 2)));
   endfunction

endpackage

// File: rtl/main_mem_responder_ram.sv
// -----------------------------------------------------------------------------
// main_mem_responder_ram
//   Single-port word RAM with registered read, used as backing storage.
//   Ports:
//     clk    in  1           clock
//     re     in  1           read enable; rdata updated at this edge
//     we     in  1           write enable; mem[addr] updated at this edge
//     addr   in  ADDR_WIDTH  word address (shared by read and write)
//     wdata  in  WIDTH       write data
//     rdata  out WIDTH       registered read data, holds between reads
// -----------------------------------------------------------------------------
module main_mem_responder_ram
   import main_mem_responder_pkg::*;
#(
   parameter int WIDTH      = WORD_W,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  re,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/main_mem_responder.sv
// -----------------------------------------------------------------------------
// main_mem_responder
//   Main-memory responder for the cache word bus. Serves one 32-bit word per
//   request after LATENCY cycles, or SEQ_LATENCY cycles for a read of the word
//   following the last served one within the same row (block refills).
//   Ports:
//     clk      in  1   clock
//     res      in  1   synchronous active-high reset
//     addr     in  32  byte address, bits [1:0] ignored
//     dataIn   in  32  write data
//     re       in  1   read request (level, held until ready)
//     we       in  1   write request (level, held until ready, wins over re)
//     dataOut  out 32  read data, valid in the ready cycle, held afterwards
//     ready    out 1   single-cycle acknowledge
// -----------------------------------------------------------------------------
module main_mem_responder
   import main_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 14,
   parameter int LATENCY     = 4,
   parameter int SEQ_LATENCY = 1,
   parameter int ROW_BITS    = 10
) (
   input  logic                clk,
   input  logic                res,
   input  logic [WORD_W-1:0]   addr,
   input  logic [WORD_W-1:0]   dataIn,
   input  logic                re,
   input  logic                we,
   output logic [WORD_W-1:0]   dataOut,
   output logic                ready
);

   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0] SEQ_CNT = CNT_W'(SEQ_LATENCY);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   state_e              state_q;
   op_e                 op_q;
   logic [29:0]         addr_q;        // latched word address of current request
   logic [29:0]         last_addr_q;   // word address of last acknowledged request
   logic                last_valid_q;
   logic [WORD_W-1:0]   wdata_q;
   logic [WORD_W-1:0]   dout_hold_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                ready_q;

   logic                req;
   op_e                 req_op;
   logic                seq_hit;
   logic [CNT_W-1:0]    lat;
   logic                enter_ack;
   logic                rd_op;
   logic                ram_re;
   logic                ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [WORD_W-1:0]   ram_rdata;

   // Byte-lane bits are never used for addressing.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^addr[1:0];

   always_comb begin
      req       = re | we;
      req_op    = we ? OP_WRITE : OP_READ;
      seq_hit   = (req_op == OP_READ) && last_valid_q &&
                  is_seq_word(addr[31:2], last_addr_q, ROW_BITS);
      lat       = seq_hit ? SEQ_CNT : LAT_CNT;
      enter_ack = 1'b0;
      case (state_q)
         ST_IDLE: enter_ack = req && (lat == ONE_CNT);
         ST_WAIT: enter_ack = req && (cnt_q == ONE_CNT);
         default: enter_ack = 1'b0;
      endcase
      // In IDLE the request is being captured this edge, so the RAM must see
      // the live bus; otherwise the latched copy is authoritative.
      ram_addr = (state_q == ST_IDLE) ? addr[ADDR_WIDTH+1:2] : addr_q[ADDR_WIDTH-1:0];
      rd_op    = (state_q == ST_IDLE) ? (req_op == OP_READ) : (op_q == OP_READ);
      // Read launched on the edge into ACK so RAM data is valid during ACK.
      ram_re   = enter_ack && rd_op && !res;
      ram_we   = (state_q == ST_ACK) && (op_q == OP_WRITE) && !res;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_READ;
         addr_q       <= '0;
         last_addr_q  <= '0;
         last_valid_q <= 1'b0;
         wdata_q      <= '0;
         dout_hold_q  <= '0;
         cnt_q        <= '0;
         ready_q      <= 1'b0;
      end else begin
         ready_q <= enter_ack;
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  addr_q  <= addr[31:2];
                  wdata_q <= dataIn;
                  op_q    <= req_op;
                  cnt_q   <= lat - ONE_CNT;
                  state_q <= (lat == ONE_CNT) ? ST_ACK : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  // Initiator withdrew: drop the request without ack or write.
                  state_q <= ST_IDLE;
               end else if (cnt_q == ONE_CNT) begin
                  state_q <= ST_ACK;
               end else begin
                  cnt_q <= cnt_q - ONE_CNT;
               end
            end
            ST_ACK: begin
               if (op_q == OP_READ) begin
                  dout_hold_q <= ram_rdata;
               end
               last_addr_q  <= addr_q;
               last_valid_q <= 1'b1;
               // Always return to IDLE so a held re is not served twice.
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   main_mem_responder_ram #(
      .WIDTH      (WORD_W),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .re    (ram_re),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // RAM output drives the bus only during a read ACK; otherwise the last
   // read word is replayed from the hold register.
   assign dataOut = ((state_q == ST_ACK) && (op_q == OP_READ)) ? ram_rdata : dout_hold_q;
   assign ready   = ready_q;

endmodule
